huff_enc_sequencer: RTL and testbench
=====================================

Name: huff_enc_sequencer

Overview:
Job-level controller that sequences the huff_encoder core. It accepts one 3-symbol job (three 8-bit characters plus three 3-bit frequencies) over a valid/ready handshake, streams the symbols into the encoder's 12-bit io_in bus over three cycles, and collects the six 9-bit output beats from io_out. It then presents the packed result over a second valid/ready handshake, with timeout protection, so upstream logic never drives the encoder pins directly.

Parameters:
TIMEOUT_CYCLES, 64, max cycles allowed without an encoder output beat once loading starts; range 1..255
NUM_BEATS, 6, encoder output beats per job (fixed by encoder; other values unsupported)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
job_valid  input  1  job offered
job_ready  output  1  sequencer can accept a job
job_chars  input  24  characters; sym0=[23:16], sym1=[15:8], sym2=[7:0]
job_freqs  input  9  frequencies; sym0=[8:6], sym1=[5:3], sym2=[2:0]
enc_io_in  output  12  to encoder io_in: {valid, freq[2:0], char[7:0]}
enc_io_out  input  12  from encoder io_out; [8]=beat valid, [7:0]=beat data
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  48  beats packed; beat0=[47:40] ... beat5=[7:0]
res_err  output  1  result is a timeout result (qualified by res_valid)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; job_ready=1, enc_io_in=0, res_valid=0, res_data=0, res_err=0, busy=0; job latch, symbol index, beat count and timeout counter cleared. Reset mid-job discards the job and produces no result.
- States: IDLE, LOAD, WAIT, DONE. All outputs registered.
- IDLE: job_ready=1. On job_valid&&job_ready at edge T, latch chars/freqs, go to LOAD. In the cycle after T, enc_io_in={1,freq0,char0}.
- LOAD: three cycles, sym0, sym1, sym2 in order, each with enc_io_in[11]=1. The edge ending sym2 drives enc_io_in=0 and moves to WAIT. Load latency: first symbol 1 cycle after acceptance.
- Beat capture runs in LOAD and WAIT. Each cycle with enc_io_out[8]=1 stores enc_io_out[7:0] into slot beat_cnt and increments beat_cnt. Beats outside LOAD/WAIT are ignored.
- Timeout counter: cleared on entering LOAD and on every captured beat; otherwise increments in LOAD/WAIT. When it reaches TIMEOUT_CYCLES with beat_cnt<6, go to DONE with res_err=1. Uncaptured slots read 0.
- When the 6th beat is captured, go to DONE with res_err=0 on the next edge. Beats after the 6th in the same job are ignored.
- DONE: res_valid=1. res_data and res_err are held stable until res_valid&&res_ready. On the handshake edge, return to IDLE and clear res_valid.
- job_ready=1 only in IDLE, so jobs never overlap. This guarantees at least one cycle with enc_io_in[11]=0 between consecutive jobs (the DONE cycle or cycles).
- No combinational path from res_ready to job_ready. Back-to-back minimum job period is 3 (LOAD) + encoder latency + 1 (DONE) + 1 (IDLE) cycles.
- job_chars/job_freqs may change after acceptance without effect.

Test Plan:
- Basic load: job_chars=0x616263, job_freqs=0b011_010_001, job_valid=1 → job_ready drops. enc_io_in shows 0xB61, 0xA62, 0x963 on consecutive cycles starting 1 cycle after acceptance, then 0x000.
- Collection: after load, model drives 6 beats with [8]=1 and data 0x11,0x22,0x33,0x44,0x55,0x66, including 2 idle gap cycles between beats 3 and 4 → res_valid=1, res_data=0x112233445566, res_err=0.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_data/res_valid stable, job_ready=0, a new job_valid is not accepted. Raise res_ready → IDLE next cycle, job_ready=1.
- Timeout: TIMEOUT_CYCLES=8, model returns 2 beats (0xAA,0xBB) then stops → DONE exactly 8 cycles after beat 2. res_err=1, res_data=0xAABB00000000.
- Reset mid-job: assert reset during LOAD sym1 → enc_io_in=0 and state IDLE immediately (asynchronous). After release, a fresh job completes normally with no residual beats.
- Stray/extra beats: drive a beat in IDLE and a 7th beat in the cycle the 6th beat is captured → neither affects res_data. Beat count for the next job starts at 0.

Source files
------------

// File: rtl/huff_enc_sequencer.sv
// Job-level sequencer for the huff_encoder core: loads a 3-symbol job onto io_in,
// gathers the six io_out beats and hands back the packed result, with a stall timeout.
module huff_enc_sequencer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NUM_BEATS      = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [23:0] job_chars,
   input  logic [8:0]  job_freqs,
   output logic [11:0] enc_io_in,
   input  logic [11:0] enc_io_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [47:0] res_data,
   output logic        res_err,
   output logic        busy
);

   localparam logic [8:0] TMO_LIM   = 9'(TIMEOUT_CYCLES);
   localparam logic [2:0] LAST_BEAT = 3'(NUM_BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

   state_t          r_state, w_state_nx;
   logic [23:0]     r_chars;
   logic [8:0]      r_freqs;
   logic [1:0]      r_sym_idx, w_sym_idx_nx;
   logic [2:0]      r_beat_cnt;
   logic [7:0]      r_tmo;
   logic [0:5][7:0] r_beats;
   logic [11:0]     r_io_in, w_io_in_nx;
   logic            r_res_err, r_res_valid, r_job_ready, r_busy;

   logic            w_accept, w_active, w_beat, w_last_beat, w_tmo_hit;
   logic [23:0]     w_src_chars;
   logic [8:0]      w_src_freqs;

   assign w_accept    = (r_state == S_IDLE) && job_valid;
   assign w_active    = (r_state == S_LOAD) || (r_state == S_WAIT);
   assign w_beat      = w_active && enc_io_out[8] && (r_beat_cnt <= LAST_BEAT);
   assign w_last_beat = w_beat && (r_beat_cnt == LAST_BEAT);
   // Trip on the edge where the count would reach the limit, so DONE lands
   // exactly TIMEOUT_CYCLES edges after the last captured beat.
   assign w_tmo_hit   = w_active && !w_beat && (({1'b0, r_tmo} + 9'd1) == TMO_LIM);

   // On the accept edge the first symbol comes straight from the job inputs.
   assign w_src_chars = (r_state == S_IDLE) ? job_chars : r_chars;
   assign w_src_freqs = (r_state == S_IDLE) ? job_freqs : r_freqs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx   = r_state;
      w_sym_idx_nx = r_sym_idx;
      w_io_in_nx   = 12'h000;
      case (r_state)
         S_IDLE: begin
            if (job_valid) begin
               w_state_nx   = S_LOAD;
               w_sym_idx_nx = 2'd0;
            end
         end
         S_LOAD: begin
            if (w_last_beat || w_tmo_hit) w_state_nx = S_DONE;
            else if (r_sym_idx == 2'd2)   w_state_nx = S_WAIT;
            else                          w_sym_idx_nx = r_sym_idx + 2'd1;
         end
         S_WAIT: begin
            if (w_last_beat || w_tmo_hit) w_state_nx = S_DONE;
         end
         S_DONE: begin
            if (res_ready) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (w_state_nx == S_LOAD) begin
         case (w_sym_idx_nx)
            2'd0:    w_io_in_nx = {1'b1, w_src_freqs[8:6], w_src_chars[23:16]};
            2'd1:    w_io_in_nx = {1'b1, w_src_freqs[5:3], w_src_chars[15:8]};
            default: w_io_in_nx = {1'b1, w_src_freqs[2:0], w_src_chars[7:0]};
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chars     <= '0;
         r_freqs     <= '0;
         r_sym_idx   <= '0;
         r_beat_cnt  <= '0;
         r_tmo       <= '0;
         r_beats     <= '0;
         r_io_in     <= '0;
         r_res_err   <= 1'b0;
         r_res_valid <= 1'b0;
         r_job_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_sym_idx   <= w_sym_idx_nx;
         r_io_in     <= w_io_in_nx;
         r_job_ready <= (w_state_nx == S_IDLE);
         r_busy      <= (w_state_nx != S_IDLE);
         r_res_valid <= (w_state_nx == S_DONE);
         if (w_accept) begin
            r_chars    <= job_chars;
            r_freqs    <= job_freqs;
            r_beat_cnt <= '0;
            r_tmo      <= '0;
            r_beats    <= '0;
            r_res_err  <= 1'b0;
         end else if (w_beat) begin
            r_beats[r_beat_cnt] <= enc_io_out[7:0];
            r_beat_cnt          <= r_beat_cnt + 3'd1;
            r_tmo               <= '0;
         end else if (w_active) begin
            r_tmo <= r_tmo + 8'd1;
         end
         if (w_active && (w_state_nx == S_DONE))
            r_res_err <= !w_last_beat;
      end
   end

   assign job_ready = r_job_ready;
   assign enc_io_in = r_io_in;
   assign res_valid = r_res_valid;
   assign res_data  = r_beats;
   assign res_err   = r_res_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_huff_enc_sequencer.sv
// Scoreboarded bench for huff_enc_sequencer: stimulus queues expected io_in symbols
// and results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_huff_enc_sequencer;
   localparam int TMO = 8;

   logic        clk = 1'b0, reset = 1'b1;
   logic        job_valid = 1'b0, job_ready;
   logic [23:0] job_chars = '0;
   logic [8:0]  job_freqs = '0;
   logic [11:0] enc_io_in, enc_io_out = '0;
   logic        res_valid, res_ready = 1'b0, res_err, busy;
   logic [47:0] res_data;

   huff_enc_sequencer #(.TIMEOUT_CYCLES(TMO), .NUM_BEATS(6)) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_chars(job_chars), .job_freqs(job_freqs), .enc_io_in(enc_io_in),
      .enc_io_out(enc_io_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   logic [11:0] q_io[$];
   logic [48:0] q_res[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %h expected nothing", nm, act);
   endtask

   // Monitor: compares every presented symbol / result against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (enc_io_in[11]) begin
            if (q_io.size() == 0) unexpected("io_seq", 64'(enc_io_in));
            else chk("io_seq", 64'(enc_io_in), 64'(q_io.pop_front()));
         end
         if (res_valid && res_ready) begin
            if (q_res.size() == 0) unexpected("result", {15'd0, res_err, res_data});
            else chk("result", {15'd0, res_err, res_data}, 64'(q_res.pop_front()));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d);
      enc_io_out = {3'b000, 1'b1, d};
      cyc();
      enc_io_out = '0;
   endtask

   task automatic send_job(input logic [23:0] ch, input logic [8:0] fr, input int nsym);
      int n;
      for (int k = 0; k < nsym; k++)
         q_io.push_back({1'b1, fr[8-3*k -: 3], ch[23-8*k -: 8]});
      job_chars = ch;
      job_freqs = fr;
      job_valid = 1'b1;
      n = 0;
      while (!job_ready && n < 50) begin
         cyc();
         n++;
      end
      if (n == 50) unexpected("job_accept_timeout", 64'(n));
      cyc();
      job_valid = 1'b0;
      job_chars = ~ch;
      job_freqs = ~fr;
   endtask

   task automatic release_result();
      int n;
      res_ready = 1'b1;
      n = 0;
      while (!res_valid && n < 50) begin
         cyc();
         n++;
      end
      if (n == 50) unexpected("result_timeout", 64'(n));
      cyc();
      res_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [47:0] held;
      int n;
      cyc(); cyc();
      chk("rst_job_ready", 64'(job_ready), 64'd1);
      chk("rst_io_in",     64'(enc_io_in), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data",  64'(res_data),  64'd0);
      chk("rst_res_err",   64'(res_err),   64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      reset = 1'b0;
      cyc();

      // Stray beat while idle must be ignored.
      beat(8'h99);
      cyc();

      // Basic load + collection with gap, extra 7th beat, backpressure.
      q_res.push_back({1'b0, 48'h112233445566});
      send_job(24'h616263, 9'b011_010_001, 3);
      chk("sym0_latency", 64'(enc_io_in), 64'hB61);
      chk("job_ready_drop", 64'(job_ready), 64'd0);
      chk("busy_load", 64'(busy), 64'd1);
      cyc(); cyc(); cyc();
      chk("load_end_zero", 64'(enc_io_in), 64'd0);
      beat(8'h11); beat(8'h22); beat(8'h33);
      cyc(); cyc();
      beat(8'h44); beat(8'h55); beat(8'h66);
      chk("done_after_6th", 64'(res_valid), 64'd1);
      chk("done_err0", 64'(res_err), 64'd0);
      beat(8'h77);
      held = res_data;
      job_valid = 1'b1;
      job_chars = 24'h414141;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 64'(res_valid), 64'd1);
         chk("bp_data", 64'(res_data), 64'(held));
         chk("bp_job_ready", 64'(job_ready), 64'd0);
         cyc();
      end
      job_valid = 1'b0;
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      chk("hs_valid_clr", 64'(res_valid), 64'd0);
      chk("hs_job_ready", 64'(job_ready), 64'd1);
      chk("hs_busy", 64'(busy), 64'd0);

      // Timeout after two beats.
      q_res.push_back({1'b1, 48'hAABB00000000});
      send_job(24'h414243, 9'b001_001_001, 3);
      cyc(); cyc(); cyc();
      beat(8'hAA);
      beat(8'hBB);
      n = 0;
      while (!res_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("tmo_cycles", 64'(n), 64'd8);
      chk("tmo_err", 64'(res_err), 64'd1);
      release_result();

      // Asynchronous reset during sym1.
      send_job(24'h313233, 9'b111_110_101, 2);
      cyc();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("arst_io_in", 64'(enc_io_in), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_job_ready", 64'(job_ready), 64'd1);
      chk("arst_res_valid", 64'(res_valid), 64'd0);
      #1 reset = 1'b0;
      cyc();

      // Fresh job, beats begin while symbols are still loading.
      q_res.push_back({1'b0, 48'h010203040506});
      send_job(24'h616263, 9'b011_010_001, 3);
      beat(8'h01); beat(8'h02); beat(8'h03);
      beat(8'h04); beat(8'h05); beat(8'h06);
      chk("fresh_done", 64'(res_valid), 64'd1);
      release_result();

      cyc(); cyc();
      chk("io_queue_empty", 64'(q_io.size()), 64'd0);
      chk("res_queue_empty", 64'(q_res.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
